reset_sequencer: RTL
====================

# reset_sequencer

The reset sequencer is the synchronous controller that owns processor reset. It collects reset sources: the system reset, power-good, the front-panel reset switch and a watchdog. It keeps the core in reset for a guaranteed minimum time, then holds the reset vector on the bus while the core starts up. Finally it releases the instruction-register reset when the microcode signals its first fetch. It sits between the front panel / power supply and the core's reset and reset-hold nets, and records why the last reset happened.

## Interface

Parameters:
- `ASSERT_TICKS`, default 4: minimum number of cycles spent in ASSERT (≥1).
- `HOLD_TICKS`, default 16: exact number of cycles spent in HOLD (≥1).
- `DEBOUNCE`, default 4: number of consecutive synchronised-high samples of `fpreset` needed to accept a front-panel reset (≥1).
- `WDT_TICKS`, default 65535: watchdog timeout, in cycles without a kick (≥2).
- `VECTOR`, default 16'hfff0: reset vector value.

Ports (clock and reset first):
- `clk1`  in  1  processor clock; every flop uses its rising edge.
- `reset`  in  1  synchronous, active-high system reset.
- `fpreset`  in  1  front-panel reset switch, active high, asynchronous and bouncy.
- `powerok`  in  1  power-good, active high, asynchronous.
- `wdt_en`  in  1  watchdog enable.
- `wdt_kick`  in  1  watchdog restart, one-cycle pulse.
- `go_fetch`  in  1  microcode has reached its first fetch.
- `nreset_o`  out  1  core reset, active low.
- `nrsthold`  out  1  reset-hold, active low.
- `vec_oe`  out  1  reset-vector bus enable.
- `vec`  out  16  reset vector; reads `VECTOR` when `vec_oe`=1, otherwise 0.
- `ir_rst`  out  1  instruction-register reset.
- `rst_cause`  out  2  cause of the last reset: 00 system reset, 01 power fail, 10 front panel, 11 watchdog.

## Operation

- Source conditioning:
  - `powerok` and `fpreset` each pass through a 2-flop synchroniser.
  - `pf` is the synchronised `powerok` being 0.
  - `fp` asserts once the synchronised `fpreset` has been 1 for `DEBOUNCE` consecutive cycles. It stays asserted until the first synchronised 0.
  - `wd` asserts when the watchdog counter expires.
- Watchdog counter:
  - Counts only in RUN with `wdt_en`=1.
  - Cleared by `wdt_kick`, by `wdt_en`=0 and on leaving RUN.
  - Expires when it reaches `WDT_TICKS`-1 with no kick that cycle.
  - Kick and expiry in the same cycle: the kick wins and no reset occurs.
- State machine (ASSERT, HOLD, WAIT, RUN):
  - ASSERT: `nreset_o`=0, `nrsthold`=0, `vec_oe`=0, `ir_rst`=1.
    - Exit to HOLD once `pf`=0, `fp`=0 and at least `ASSERT_TICKS` cycles have been spent in the state.
  - HOLD: `nreset_o`=1, `nrsthold`=0, `vec_oe`=1, `ir_rst`=1.
    - Exit to WAIT after exactly `HOLD_TICKS` cycles.
    - `go_fetch` is ignored in HOLD.
  - WAIT: `nreset_o`=1, `nrsthold`=1, `vec_oe`=0, `ir_rst`=1.
    - Exit to RUN on `go_fetch`=1.
  - RUN: `ir_rst`=0 and all other outputs are inactive.
- Any `pf`, `fp` or `wd` in any state forces ASSERT on the next edge and clears the tick counter.
  - While already in ASSERT, the `ASSERT_TICKS` count restarts whenever a source is active.
- `rst_cause` is loaded on entry to ASSERT from another state, and on `reset`.
  - Priority: `reset` > `pf` > `fp` > `wd`.
  - Holds its value until the next entry.
- All outputs are registered; none are combinational from inputs.

## Timing

- `reset`=1 at an edge gives: state ASSERT, counters and synchronisers cleared (`fp`=0), `nreset_o`=0, `nrsthold`=0, `vec_oe`=0, `vec`=0, `ir_rst`=1, `rst_cause`=00.
- Reset applied mid-sequence (any state) has the same effect.
- `powerok` falling to `nreset_o`=0: 3 edges (2 synchroniser + 1 state register).
- `fpreset` rising to `nreset_o`=0: 2 + `DEBOUNCE` + 1 edges, if the input stays stable.
- ASSERT to RUN with no sources active: `ASSERT_TICKS` + `HOLD_TICKS` cycles, plus the WAIT cycles.
- `go_fetch` sampled high in WAIT: `ir_rst`=0 from the next edge.
- Watchdog expiry: ASSERT on the edge after the counter reaches `WDT_TICKS`-1.

## Test plan

- System reset, then no sources, `go_fetch`=1 at WAIT cycle 3:
  - `nreset_o` rises after 4 cycles.
  - `vec`=16'hfff0 with `vec_oe`=1 for exactly 16 cycles.
  - `ir_rst` falls 1 cycle after `go_fetch`.
  - `rst_cause`=00.
- `powerok` dropped for 1 cycle while in RUN:
  - `nreset_o`=0 3 edges later.
  - The full sequence replays.
  - `rst_cause`=01.
- `fpreset` bounce pattern 1,0,1,1,0 then held high for 10 cycles:
  - Exactly one ASSERT, entered 2+4+1 edges after the stable run begins.
  - Stays in ASSERT until release plus 4 cycles.
  - `rst_cause`=10.
- `WDT_TICKS`=8 with `wdt_en`=1:
  - Kicks every 5 cycles: no reset.
  - Kicks stop: ASSERT after 8 cycles, `rst_cause`=11.
  - A kick issued on the expiry cycle prevents the reset.
- `powerok` dropped at HOLD cycle 7: ASSERT, then a full 4 + 16 cycle sequence with no shortened hold.
- `go_fetch` held high from HOLD onward: HOLD still lasts exactly 16 cycles, then WAIT for 1 cycle, then RUN.

Source files
------------

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Processor reset controller. It gathers four reset sources: system reset,
// power-good, the front-panel switch and a watchdog. It then steps the core
// through ASSERT -> HOLD -> WAIT -> RUN:
//   ASSERT : core held in reset for at least ASSERT_TICKS quiet cycles
//   HOLD   : core out of reset, reset vector driven for exactly HOLD_TICKS
//   WAIT   : waiting for the microcode to reach its first fetch
//   RUN    : instruction-register reset released, watchdog armed
// It also records the cause of the most recent reset.
//
// Ports
//   clk1       in   processor clock, rising edge
//   reset      in   synchronous active-high system reset
//   fpreset    in   front-panel switch (async, bouncy, active high)
//   powerok    in   power-good (async, active high)
//   wdt_en     in   watchdog enable
//   wdt_kick   in   watchdog restart pulse
//   go_fetch   in   microcode first-fetch indication
//   nreset_o   out  core reset, active low
//   nrsthold   out  reset-hold, active low
//   vec_oe     out  reset-vector bus enable
//   vec        out  reset vector (VECTOR while vec_oe, else 0)
//   ir_rst     out  instruction-register reset
//   rst_cause  out  00 system, 01 power fail, 10 front panel, 11 watchdog
//
// All outputs come straight from flops. They are loaded from the next state
// on the same edge that updates the state register, so no output depends
// combinationally on an input.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int          ASSERT_TICKS = 4,
    parameter int          HOLD_TICKS   = 16,
    parameter int          DEBOUNCE     = 4,
    parameter int          WDT_TICKS    = 65535,
    parameter logic [15:0] VECTOR       = 16'hfff0
) (
    input  logic        clk1,
    input  logic        reset,
    input  logic        fpreset,
    input  logic        powerok,
    input  logic        wdt_en,
    input  logic        wdt_kick,
    input  logic        go_fetch,
    output logic        nreset_o,
    output logic        nrsthold,
    output logic        vec_oe,
    output logic [15:0] vec,
    output logic        ir_rst,
    output logic [1:0]  rst_cause
);

    // -------------------------------------------------------------------------
    // Widths and terminal counts
    // -------------------------------------------------------------------------
    localparam int TMAX = (ASSERT_TICKS > HOLD_TICKS) ? ASSERT_TICKS : HOLD_TICKS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int DW   = $clog2(DEBOUNCE + 1);
    localparam int WW   = $clog2(WDT_TICKS);

    localparam logic [TW-1:0] ASSERT_LAST = TW'(ASSERT_TICKS - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_TICKS - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE - 1);
    localparam logic [WW-1:0] WDT_LAST    = WW'(WDT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // Two-flop synchronisers: bit 0 = powerok, bit 1 = fpreset.
    // The clear value is "no source pending". powerok therefore clears to 1,
    // so a system reset does not add a spurious power-fail window on top of
    // the ASSERT time. fpreset clears to 0.
    // -------------------------------------------------------------------------
    localparam int          NSRC      = 2;
    localparam logic [1:0]  SYNC_INIT = 2'b01;

    logic [NSRC-1:0] raw_in;
    logic [NSRC-1:0] sync_bus;

    assign raw_in = {fpreset, powerok};

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_sync
            logic meta_q;
            logic sync_q;

            always_ff @(posedge clk1) begin
                if (reset) begin
                    meta_q <= SYNC_INIT[gi];
                    sync_q <= SYNC_INIT[gi];
                end else begin
                    meta_q <= raw_in[gi];
                    sync_q <= meta_q;
                end
            end

            assign sync_bus[gi] = sync_q;
        end
    endgenerate

    logic pok_sync;
    logic fpr_sync;

    assign pok_sync = sync_bus[0];
    assign fpr_sync = sync_bus[1];

    // -------------------------------------------------------------------------
    // Front-panel debounce.
    // fp_q sets on the DEBOUNCE-th consecutive synchronised-high sample. It
    // clears on the first synchronised-low sample. The counter stops at
    // DEBOUNCE-1 because its only job is to reach that threshold.
    // -------------------------------------------------------------------------
    logic [DW-1:0] deb_cnt_q;
    logic          fp_q;

    always_ff @(posedge clk1) begin
        if (reset) begin
            deb_cnt_q <= '0;
            fp_q      <= 1'b0;
        end else if (!fpr_sync) begin
            deb_cnt_q <= '0;
            fp_q      <= 1'b0;
        end else begin
            if (deb_cnt_q == DEB_LAST) begin
                fp_q <= 1'b1;
            end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Reset sources
    // -------------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] tick_q;
    logic [TW-1:0] tick_d;
    logic [WW-1:0] wdt_cnt_q;
    logic [WW-1:0] wdt_cnt_d;
    logic [1:0]    cause_d;

    logic pf;
    logic fp;
    logic wd;
    logic src_active;

    assign pf = ~pok_sync;
    assign fp = fp_q;
    // A kick on the expiry cycle wins, so the kick term masks expiry.
    assign wd = (state_q == ST_RUN) && wdt_en && !wdt_kick && (wdt_cnt_q == WDT_LAST);
    assign src_active = pf | fp | wd;

    // -------------------------------------------------------------------------
    // Next-state, tick counter, watchdog counter and cause
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;

        if (src_active) begin
            // A source restarts the minimum ASSERT time, even when the
            // sequencer is already in ASSERT.
            state_d = ST_ASSERT;
            tick_d  = '0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (tick_q == ASSERT_LAST) begin
                        state_d = ST_HOLD;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_HOLD: begin
                    // go_fetch is deliberately ignored here. HOLD always
                    // runs its full length.
                    if (tick_q == HOLD_LAST) begin
                        state_d = ST_WAIT;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
                ST_WAIT: begin
                    if (go_fetch) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_ASSERT;
                    tick_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        // The watchdog counts only while the sequencer stays in RUN. Any
        // kick, disable, or departure from RUN returns it to zero.
        wdt_cnt_d = '0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN) && wdt_en && !wdt_kick) begin
            wdt_cnt_d = wdt_cnt_q + WW'(1);
        end
    end

    always_comb begin
        // The cause is captured only on entry to ASSERT from another state.
        // Sources that stay active while in ASSERT do not overwrite it.
        cause_d = rst_cause;
        if ((state_d == ST_ASSERT) && (state_q != ST_ASSERT)) begin
            if (pf) begin
                cause_d = 2'b01;
            end else if (fp) begin
                cause_d = 2'b10;
            end else begin
                cause_d = 2'b11;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q   <= ST_ASSERT;
            tick_q    <= '0;
            wdt_cnt_q <= '0;
            nreset_o  <= 1'b0;
            nrsthold  <= 1'b0;
            vec_oe    <= 1'b0;
            vec       <= 16'h0000;
            ir_rst    <= 1'b1;
            rst_cause <= 2'b00;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            wdt_cnt_q <= wdt_cnt_d;
            rst_cause <= cause_d;

            unique case (state_d)
                ST_HOLD: begin
                    nreset_o <= 1'b1;
                    nrsthold <= 1'b0;
                    vec_oe   <= 1'b1;
                    vec      <= VECTOR;
                    ir_rst   <= 1'b1;
                end
                ST_WAIT: begin
                    nreset_o <= 1'b1;
                    nrsthold <= 1'b1;
                    vec_oe   <= 1'b0;
                    vec      <= 16'h0000;
                    ir_rst   <= 1'b1;
                end
                ST_RUN: begin
                    nreset_o <= 1'b1;
                    nrsthold <= 1'b1;
                    vec_oe   <= 1'b0;
                    vec      <= 16'h0000;
                    ir_rst   <= 1'b0;
                end
                default: begin
                    nreset_o <= 1'b0;
                    nrsthold <= 1'b0;
                    vec_oe   <= 1'b0;
                    vec      <= 16'h0000;
                    ir_rst   <= 1'b1;
                end
            endcase
        end
    end

endmodule
